// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
package hazard_pkg;

    localparam int AW_DEF     = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [AW_DEF-1:0] REG_ZERO = '0;

    // Slot widths follow the package defaults; hazard_unit must be built with matching AW/DATA_W.
    typedef struct packed {
        logic                  valid;
        logic [AW_DEF-1:0]     wreg;
        logic                  load;
        logic                  ready;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

endpackage

// File: rtl/hazard_fwd_lookup.sv
// Per-source priority match over the in-flight slots: forwarded operand plus stall request.
// HAZARD_EX_BYPASS_EN: an ALU producer in slot 0 forwards ex_data combinationally.
module fwd_lookup
    import hazard_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  slot_t [DEPTH-1:0]  slots,
    input  logic  [AW-1:0]     addr,
    input  logic  [DATA_W-1:0] regdata,
    input  logic  [DATA_W-1:0] ex_data,
    output logic  [DATA_W-1:0] fwd,
    output logic               req
);

    logic              hit;
    logic              win_s0;
    logic              win_load;
    logic              win_rdy;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        hit      = 1'b0;
        win_s0   = 1'b0;
        win_load = 1'b0;
        win_rdy  = 1'b0;
        win_data = '0;
        // Scan oldest to youngest so the lowest-index match overwrites older ones.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots[i].valid && slots[i].wreg == addr) begin
                hit      = 1'b1;
                win_s0   = (i == 0);
                win_load = slots[i].load;
                win_rdy  = slots[i].ready;
                win_data = slots[i].data;
            end
        end
        if (addr == REG_ZERO)
            hit = 1'b0;
`ifdef HAZARD_EX_BYPASS_EN
        if (win_s0 && !win_load) begin
            win_rdy  = 1'b1;
            win_data = ex_data;
        end
`endif
        fwd = regdata;
        req = 1'b0;
        if (hit) begin
            if (win_rdy)
                fwd = win_data;
            else
                req = 1'b1;
        end
    end

`ifndef HAZARD_EX_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{ex_data, win_s0, win_load};
`endif

endmodule

// File: rtl/hazard_unit.sv
// In-flight destination scoreboard: RAW detection, operand forwarding, load-use stall, write-back.
// Optional combinational ALU->decode bypass under HAZARD_EX_BYPASS_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AW       = AW_DEF,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic              sysclk,
    input  logic              rstd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_wreg,
    input  logic              iss_load,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    input  logic [DATA_W-1:0] rs_regdata,
    input  logic [DATA_W-1:0] rt_regdata,
    output logic [DATA_W-1:0] os_fwd,
    output logic [DATA_W-1:0] ot_fwd,
    output logic              stall,
    output logic              wb_we,
    output logic [AW-1:0]     wb_wreg,
    output logic [DATA_W-1:0] wb_data
);

    slot_t [DEPTH-1:0] slots;
    slot_t [DEPTH-1:0] slots_nxt;
    logic              rs_req;
    logic              rt_req;

    fwd_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_rs (
        .slots(slots), .addr(rs_addr), .regdata(rs_regdata), .ex_data(ex_data),
        .fwd(os_fwd), .req(rs_req)
    );

    fwd_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_rt (
        .slots(slots), .addr(rt_addr), .regdata(rt_regdata), .ex_data(ex_data),
        .fwd(ot_fwd), .req(rt_req)
    );

    // Flush drops the issuing instruction, so any hazard it had is moot.
    assign stall = (rs_req | rt_req) & ~flush;

    always_comb begin
        slots_nxt          = '0;
        slots_nxt[0].valid = iss_valid & ~stall & ~flush;
        slots_nxt[0].wreg  = iss_wreg;
        slots_nxt[0].load  = iss_load;
        for (int i = 1; i < DEPTH; i++) begin
            slots_nxt[i] = slots[i-1];
            if (i == 1 && !slots[0].load) begin
                slots_nxt[i].ready = 1'b1;
                slots_nxt[i].data  = ex_data;
            end
            if (i == LOAD_LAT && slots[i-1].load) begin
                slots_nxt[i].ready = 1'b1;
                slots_nxt[i].data  = ld_data;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rstd) begin
        if (!rstd)
            slots <= '0;
        else
            slots <= slots_nxt;
    end

    // The retiring slot still takes part in lookup, covering the register-file write latency.
    assign wb_we   = slots[DEPTH-1].valid & (slots[DEPTH-1].wreg != REG_ZERO);
    assign wb_wreg = slots[DEPTH-1].valid ? slots[DEPTH-1].wreg : '0;
    assign wb_data = slots[DEPTH-1].valid ? slots[DEPTH-1].data : '0;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (DEPTH=3, LOAD_LAT=2), both bypass builds.
module tb_hazard_unit;

    logic        sysclk = 1'b0;
    logic        rstd;
    logic        iss_valid, iss_load, flush;
    logic [4:0]  iss_wreg, rs_addr, rt_addr;
    logic [31:0] ex_data, ld_data, rs_regdata, rt_regdata;
    logic [31:0] os_fwd, ot_fwd, wb_data;
    logic        stall, wb_we;
    logic [4:0]  wb_wreg;

    int total = 0;
    int bad   = 0;

    hazard_unit #(.DATA_W(32), .AW(5), .DEPTH(3), .LOAD_LAT(2)) dut (
        .sysclk(sysclk), .rstd(rstd),
        .iss_valid(iss_valid), .iss_wreg(iss_wreg), .iss_load(iss_load), .flush(flush),
        .ex_data(ex_data), .ld_data(ld_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_regdata(rs_regdata), .rt_regdata(rt_regdata),
        .os_fwd(os_fwd), .ot_fwd(ot_fwd), .stall(stall),
        .wb_we(wb_we), .wb_wreg(wb_wreg), .wb_data(wb_data)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 after the edge, checks 2 after the edge.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_wreg = 5'd0; iss_load = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rstd = 1'b0;
        idle();
        ex_data = 32'h0; ld_data = 32'h0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        rs_regdata = 32'h55; rt_regdata = 32'h66;
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_wreg", {27'd0, wb_wreg}, 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_os_fwd", os_fwd, 32'h55);
        chk("rst_ot_fwd", ot_fwd, 32'h66);
        rstd = 1'b1;
        tick();

        // ALU back-to-back on r3
        iss_valid = 1'b1; iss_wreg = 5'd3;
        tick();
        idle(); ex_data = 32'h11; rs_addr = 5'd3; settle();
`ifdef HAZARD_EX_BYPASS_EN
        chk("alu_b2b_stall", {31'd0, stall}, 32'd0);
        chk("alu_b2b_os", os_fwd, 32'h11);
`else
        chk("alu_b2b_stall", {31'd0, stall}, 32'd1);
`endif
        tick();
        ex_data = 32'h0; settle();
        chk("alu_s1_stall", {31'd0, stall}, 32'd0);
        chk("alu_s1_os", os_fwd, 32'h11);
        tick();
        rs_addr = 5'd0; settle();
        chk("alu_wb_we", {31'd0, wb_we}, 32'd1);
        chk("alu_wb_wreg", {27'd0, wb_wreg}, 32'd3);
        chk("alu_wb_data", wb_data, 32'h11);
        tick();
        chk("alu_wb_done", {31'd0, wb_we}, 32'd0);

        // Load-use on r4; a stalled issue of r9 must become a bubble
        iss_valid = 1'b1; iss_wreg = 5'd4; iss_load = 1'b1; ex_data = 32'h99;
        tick();
        iss_valid = 1'b1; iss_wreg = 5'd9; iss_load = 1'b0; ex_data = 32'h0;
        rt_addr = 5'd4; settle();
        chk("ld_stall_c1", {31'd0, stall}, 32'd1);
        tick();
        idle(); ld_data = 32'hAB; settle();
        chk("ld_stall_c2", {31'd0, stall}, 32'd1);
        tick();
        ld_data = 32'h0; settle();
        chk("ld_stall_c3", {31'd0, stall}, 32'd0);
        chk("ld_ot", ot_fwd, 32'hAB);
        chk("ld_os_reg", os_fwd, 32'h55);
        chk("ld_wb_we", {31'd0, wb_we}, 32'd1);
        chk("ld_wb_wreg", {27'd0, wb_wreg}, 32'd4);
        chk("ld_wb_data", wb_data, 32'hAB);
        tick();
        rt_addr = 5'd0; settle();
        chk("stalled_issue_no_wb", {31'd0, wb_we}, 32'd0);
        tick();

        // Youngest wins: r5<-1 then r5<-2
        iss_valid = 1'b1; iss_wreg = 5'd5;
        tick();
        ex_data = 32'h1;
        tick();
        idle(); ex_data = 32'h2; rs_addr = 5'd5; settle();
`ifdef HAZARD_EX_BYPASS_EN
        chk("yw_s0_stall", {31'd0, stall}, 32'd0);
        chk("yw_s0_os", os_fwd, 32'h2);
`else
        chk("yw_s0_stall", {31'd0, stall}, 32'd1);
`endif
        tick();
        ex_data = 32'h0; settle();
        chk("yw_os", os_fwd, 32'h2);
        chk("yw_stall", {31'd0, stall}, 32'd0);
        chk("yw_wb1_we", {31'd0, wb_we}, 32'd1);
        chk("yw_wb1_data", wb_data, 32'h1);
        tick();
        chk("yw_os_retire", os_fwd, 32'h2);
        chk("yw_wb2_we", {31'd0, wb_we}, 32'd1);
        chk("yw_wb2_wreg", {27'd0, wb_wreg}, 32'd5);
        chk("yw_wb2_data", wb_data, 32'h2);
        rs_addr = 5'd0;
        tick();
        chk("yw_wb_done", {31'd0, wb_we}, 32'd0);

        // Register zero destination
        iss_valid = 1'b1; iss_wreg = 5'd0; rs_regdata = 32'h0;
        tick();
        idle(); ex_data = 32'hFF; settle();
        chk("r0_os", os_fwd, 32'h0);
        chk("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        ex_data = 32'h0; settle();
        chk("r0_wb_s1", {31'd0, wb_we}, 32'd0);
        tick();
        chk("r0_wb_s2", {31'd0, wb_we}, 32'd0);
        rs_regdata = 32'h55;
        tick();

        // Flush together with a pending load-use stall
        iss_valid = 1'b1; iss_wreg = 5'd6; iss_load = 1'b1;
        tick();
        iss_valid = 1'b1; iss_wreg = 5'd7; iss_load = 1'b0; flush = 1'b1;
        rs_addr = 5'd6; settle();
        chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        idle(); rs_addr = 5'd7; rt_addr = 5'd6; ld_data = 32'hC6; settle();
        chk("fl_r7_os", os_fwd, 32'h55);
        chk("fl_r6_stall", {31'd0, stall}, 32'd1);
        tick();
        ld_data = 32'h0; settle();
        chk("fl_r6_stall_end", {31'd0, stall}, 32'd0);
        chk("fl_r6_ot", ot_fwd, 32'hC6);
        chk("fl_r6_wb_wreg", {27'd0, wb_wreg}, 32'd6);
        tick();
        rs_addr = 5'd0; rt_addr = 5'd0; settle();
        chk("fl_r7_no_wb", {31'd0, wb_we}, 32'd0);
        tick();

        // Asynchronous reset with a load to r4 in slot 1
        iss_valid = 1'b1; iss_wreg = 5'd4; iss_load = 1'b1;
        tick();
        idle();
        tick();
        rt_addr = 5'd4; settle();
        chk("rl_stall_pre", {31'd0, stall}, 32'd1);
        rstd = 1'b0; settle();
        chk("rl_stall", {31'd0, stall}, 32'd0);
        chk("rl_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rl_ot", ot_fwd, 32'h66);
        rstd = 1'b1; ld_data = 32'hAB;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rl_no_wb", {31'd0, wb_we}, 32'd0);
        end
        chk("rl_stall_post", {31'd0, stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
